aes_frame_rx: RTL

AES_FRAME_RX -- requirements
Module: aes_frame_rx

---
 rtl/aes_frame_rx.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/aes_frame_rx.sv
// Receives 18-byte frames from a UART: 16 payload bytes followed by a two-byte terminator.
// Each good frame is presented as a 128-bit word that stays valid until accepted, tagged as key or plaintext.
module aes_frame_rx #(
   parameter int         TIMEOUT_CYC = 100000,
   parameter logic [7:0] TERM0       = 8'h0D,
   parameter logic [7:0] TERM1       = 8'h0A
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   rx_data,
   input  logic         rx_valid,
   input  logic         rx_error,
   input  logic         key_reload,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         out_valid,
   output logic         out_is_key,
   output logic         frame_err,
   output logic         overrun
);

   localparam int IW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT_CYC);
   localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC - 1);

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_RESYNC  = 1'b1
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [4:0]     r_count;
   logic [4:0]     w_count_nxt;
   logic           r_t0_seen;
   logic           w_t0_seen_nxt;
   logic           w_frame_err_nxt;
   logic           w_complete;
   logic           w_shift;
   logic           w_timeout;
   logic [IW-1:0]  r_idle;
   logic [127:0]   r_payload;
   logic           r_key_flag;
   logic [127:0]   r_out_data;
   logic           r_out_valid;
   logic           r_out_is_key;
   logic           r_frame_err;
   logic           r_overrun;

   // The idle counter saturates, so a long idle stretch times out exactly once.
   assign w_timeout = !rx_valid && (r_idle == IDLE_LAST);

   // State, byte counter and resync terminator tracker
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_COLLECT;
         r_count   <= 5'd0;
         r_t0_seen <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_count   <= w_count_nxt;
         r_t0_seen <= w_t0_seen_nxt;
      end
   end

   // Next-state decode for frame collection and resynchronisation
   always_comb begin
      w_state_nxt     = r_state;
      w_count_nxt     = r_count;
      w_t0_seen_nxt   = r_t0_seen;
      w_frame_err_nxt = 1'b0;
      w_complete      = 1'b0;
      w_shift         = 1'b0;
      case (r_state)
         ST_COLLECT: begin
            w_t0_seen_nxt = 1'b0;
            if (rx_error) begin
               if (r_count != 5'd0) begin
                  w_frame_err_nxt = 1'b1;
                  w_count_nxt     = 5'd0;
                  w_state_nxt     = ST_RESYNC;
               end else begin
                  w_count_nxt = 5'd0;
               end
            end else if (rx_valid) begin
               if (r_count < 5'd16) begin
                  w_shift     = 1'b1;
                  w_count_nxt = r_count + 5'd1;
               end else if (r_count == 5'd16) begin
                  if (rx_data == TERM0) begin
                     w_count_nxt = 5'd17;
                  end else begin
                     w_frame_err_nxt = 1'b1;
                     w_count_nxt     = 5'd0;
                     w_state_nxt     = ST_RESYNC;
                  end
               end else begin
                  w_count_nxt = 5'd0;
                  if (rx_data == TERM1) begin
                     w_complete = 1'b1;
                  end else begin
                     // A stray TERM0 here may be the start of the resync pattern.
                     w_frame_err_nxt = 1'b1;
                     w_state_nxt     = ST_RESYNC;
                     w_t0_seen_nxt   = (rx_data == TERM0);
                  end
               end
            end else if (w_timeout && (r_count != 5'd0)) begin
               w_frame_err_nxt = 1'b1;
               w_count_nxt     = 5'd0;
            end else begin
               w_count_nxt = r_count;
            end
         end
         ST_RESYNC: begin
            w_count_nxt = 5'd0;
            if (rx_error) begin
               w_t0_seen_nxt = 1'b0;
            end else if (rx_valid) begin
               if (r_t0_seen && (rx_data == TERM1)) begin
                  w_state_nxt   = ST_COLLECT;
                  w_t0_seen_nxt = 1'b0;
               end else begin
                  w_t0_seen_nxt = (rx_data == TERM0);
               end
            end else if (w_timeout) begin
               w_state_nxt   = ST_COLLECT;
               w_t0_seen_nxt = 1'b0;
            end else begin
               w_t0_seen_nxt = r_t0_seen;
            end
         end
         default: begin
            w_state_nxt   = ST_COLLECT;
            w_count_nxt   = 5'd0;
            w_t0_seen_nxt = 1'b0;
         end
      endcase
   end

   // Payload shifting, idle timing, key flag and output handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idle       <= '0;
         r_payload    <= 128'd0;
         r_key_flag   <= 1'b1;
         r_out_data   <= 128'd0;
         r_out_valid  <= 1'b0;
         r_out_is_key <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_frame_err <= w_frame_err_nxt;
         r_overrun   <= 1'b0;
         if (w_shift) begin
            r_payload <= {r_payload[119:0], rx_data};
         end
         if (rx_valid) begin
            r_idle <= '0;
         end else if (r_idle != IDLE_MAX) begin
            r_idle <= r_idle + IW'(1);
         end
         if (w_complete && (!r_out_valid || out_ready)) begin
            r_out_data   <= r_payload;
            r_out_is_key <= r_key_flag || key_reload;
            r_out_valid  <= 1'b1;
            r_key_flag   <= 1'b0;
         end else begin
            // A dropped frame leaves the key flag armed for the next accepted one.
            if (w_complete) begin
               r_overrun <= 1'b1;
            end else if (r_out_valid && out_ready) begin
               r_out_valid <= 1'b0;
            end
            if (key_reload) begin
               r_key_flag <= 1'b1;
            end
         end
      end
   end

   assign out_data   = r_out_data;
   assign out_valid  = r_out_valid;
   assign out_is_key = r_out_is_key;
   assign frame_err  = r_frame_err;
   assign overrun    = r_overrun;

endmodule
